// File: rtl/udp_tx_if.sv
// udp_tx_if: stream bundle between the payload source, udp_transmitter and the
// framing stage.
//   src_port/dst_port : UDP ports, sampled with the first payload word
//   in_*              : 64-bit payload stream into the transmitter (valid/ready/last)
//   out_*             : 64-bit header+payload stream out of the transmitter
// master = source/sink side (payload producer + downstream), slave = transmitter.
interface udp_tx_if;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;

    modport master (
        output src_port, dst_port, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  src_port, dst_port, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/udp_transmitter.sv
// udp_transmitter: buffers one payload of 64-bit words, computes the UDP
// one's-complement checksum (no pseudo-header), then sends an 8-byte header
// word {src,dst,len,csum} followed by the buffered payload.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : udp_tx_if.slave - payload in, header+payload out, UDP ports
//   busy     : high whenever the FSM is not IDLE
//   done     : one-cycle pulse after the final output transfer
module udp_transmitter #(
    parameter int MAX_WORDS = 16,
    parameter int AW        = 4
) (
    input  logic     clk,
    input  logic     rst,
    udp_tx_if.slave  bus,
    output logic     busy,
    output logic     done
);
    // Word count must reach MAX_WORDS itself, so it is one bit wider than the address.
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FOLD, S_HDR, S_DATA} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rd_q, rd_d;
    logic [31:0]   acc_q, acc_d;
    logic [15:0]   src_q, src_d, dst_q, dst_d;
    logic [15:0]   len_q, len_d, csum_q, csum_d;
    logic          done_q, done_d;

    // Sized to the full address space so any AW-bit index is in range.
    logic [63:0]   buf_q [0:(1<<AW)-1];
    logic          wr_en;

    logic [31:0]   sum, fold1, fold2;
    logic [15:0]   csum_raw;
    logic          in_ready, out_valid, out_last;
    logic [63:0]   out_data;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        acc_d     = acc_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        csum_d    = csum_q;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 64'd0;
        sum       = 32'd0;
        fold1     = 32'd0;
        fold2     = 32'd0;
        csum_raw  = 16'd0;

        case (state_q)
            S_IDLE: begin
                // Only notice the word here; it is accepted in LOAD.
                if (bus.in_valid) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    acc_d   = 32'd0;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    acc_d = acc_q + 32'(bus.in_data[63:48]) + 32'(bus.in_data[47:32])
                                  + 32'(bus.in_data[31:16]) + 32'(bus.in_data[15:0]);
                    if (cnt_q == '0) begin
                        src_d = bus.src_port;
                        dst_d = bus.dst_port;
                    end
                    // A full buffer closes the datagram even without in_last.
                    if (bus.in_last || cnt_q == CW'(MAX_WORDS - 1))
                        state_d = S_FOLD;
                end
            end
            S_FOLD: begin
                len_d    = 16'({cnt_q, 3'b000}) + 16'd8;
                sum      = acc_q + 32'(src_q) + 32'(dst_q) + 32'(len_d);
                // Two end-around folds always leave a 16-bit value.
                fold1    = 32'(sum[15:0]) + 32'(sum[31:16]);
                fold2    = 32'(fold1[15:0]) + 32'(fold1[31:16]);
                csum_raw = ~fold2[15:0];
                csum_d   = (csum_raw == 16'h0000) ? 16'hFFFF : csum_raw;
                state_d  = S_HDR;
            end
            S_HDR: begin
                out_valid = 1'b1;
                out_data  = {src_q, dst_q, len_q, csum_q};
                if (bus.out_ready) begin
                    state_d = S_DATA;
                    rd_d    = '0;
                end
            end
            S_DATA: begin
                out_valid = 1'b1;
                out_data  = buf_q[rd_q[AW-1:0]];
                out_last  = (rd_q == cnt_q - CW'(1));
                if (bus.out_ready) begin
                    rd_d = rd_q + CW'(1);
                    if (out_last) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            acc_q   <= 32'd0;
            src_q   <= 16'd0;
            dst_q   <= 16'd0;
            len_q   <= 16'd0;
            csum_q  <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            acc_q   <= acc_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            done_q  <= done_d;
        end
    end

    // Payload storage needs no reset; contents are only read after being written.
    always_ff @(posedge clk) begin
        if (wr_en) buf_q[cnt_q[AW-1:0]] <= bus.in_data;
    end

    // Outputs decode the state directly so reset clears them without waiting for a clock.
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_data  = out_data;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
endmodule

// File: tb/tb_udp_transmitter.sv
module tb_udp_transmitter;
    localparam int MAXW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, done;
    udp_tx_if bus();

    udp_transmitter #(.MAX_WORDS(MAXW), .AW(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [63:0] d;
        logic        last;
        logic        hdr;
    } exp_t;

    exp_t        expq[$];
    logic [63:0] cur[$];
    logic [15:0] cur_src, cur_dst;
    logic [63:0] hdr_log[$];

    // Header from first principles: byte length, plain-integer sum, end-around carry loop.
    function automatic logic [63:0] hdr_of(input logic [15:0] s, input logic [15:0] d,
                                           input int n, input longint lanes);
        longint      t;
        logic [15:0] len, c;
        len = 16'(8 + 8 * n);
        t = lanes + longint'(s) + longint'(d) + longint'(len);
        while (t > 65535) t = (t & 65535) + (t >> 16);
        c = ~t[15:0];
        if (c == 16'h0000) c = 16'hFFFF;
        return {s, d, len, c};
    endfunction

    function automatic longint lanes_of(input logic [63:0] w);
        return longint'(w[63:48]) + longint'(w[47:32]) + longint'(w[31:16]) + longint'(w[15:0]);
    endfunction

    task automatic model_push(input logic [15:0] s, input logic [15:0] d,
                              input logic [63:0] w, input logic l);
        longint tot;
        exp_t   e;
        if (cur.size() == 0) begin cur_src = s; cur_dst = d; end
        cur.push_back(w);
        if (l || cur.size() == MAXW) begin
            tot = 0;
            foreach (cur[i]) tot += lanes_of(cur[i]);
            e.d = hdr_of(cur_src, cur_dst, cur.size(), tot); e.last = 0; e.hdr = 1;
            expq.push_back(e);
            foreach (cur[i]) begin
                e.d = cur[i]; e.last = (i == cur.size() - 1); e.hdr = 0;
                expq.push_back(e);
            end
            cur.delete();
        end
    endtask

    // ---------------- out_ready driver ----------------
    bit   toggle = 0;
    int   pi = 0;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    always @(posedge clk) begin
        #1;
        if (toggle) begin bus.out_ready = pat[pi % 4]; pi++; end
        else bus.out_ready = 1'b1;
    end

    // ---------------- compare process ----------------
    bit          done_pend = 0;
    int          xfers = 0;
    logic        prev_stall = 0;
    logic [63:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (!rst) begin
            bit nd;
            nd = 0;
            check("done", done, done_pend);
            if (prev_stall) begin
                check("hold_data", bus.out_data, prev_data);
                check("hold_last", bus.out_last, prev_last);
            end
            if (bus.out_valid) begin
                check("in_ready_low", bus.in_ready, 1'b0);
                check("busy", busy, 1'b1);
                if (expq.size() == 0) fail_now("unexpected_out_valid");
                else begin
                    check("out_data", bus.out_data, expq[0].d);
                    check("out_last", bus.out_last, expq[0].last);
                    if (bus.out_ready) begin
                        if (expq[0].hdr) hdr_log.push_back(bus.out_data);
                        if (expq[0].last) nd = 1;
                        void'(expq.pop_front());
                        xfers++;
                    end
                end
            end
            done_pend  = nd;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_word(input logic [15:0] s, input logic [15:0] d,
                             input logic [63:0] w, input logic l);
        int n = 0;
        bus.src_port = s; bus.dst_port = d; bus.in_data = w; bus.in_last = l;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 3000) begin @(negedge clk); n++; end
        if (!bus.in_ready) fail_now("send_timeout");
        else begin
            @(posedge clk);
            model_push(s, d, w, l);
        end
        #1 bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((expq.size() != 0 || busy || done_pend || done) && n < 3000) begin
            @(posedge clk); #2; n++;
        end
        if (n >= 3000) fail_now("wait_idle");
    endtask

    int base, x0, n;

    initial begin
        bus.in_valid = 0; bus.in_last = 0; bus.in_data = '0;
        bus.src_port = '0; bus.dst_port = '0; bus.out_ready = 1'b1;

        // model pinned against hand-computed headers
        check("model_t1", hdr_of(16'h1234, 16'h5678, 1, lanes_of(64'h0001_0002_0003_0004)),
              64'h1234_5678_0010_9739);
        check("model_t2", hdr_of(16'h0000, 16'h0000, 1, lanes_of(64'hFFFF_FFFF_FFFF_FFFF)),
              64'h0000_0000_0010_FFEF);

        // reset state
        #12;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // T1
        send_word(16'h1234, 16'h5678, 64'h0001_0002_0003_0004, 1'b1);
        wait_idle();
        check("t1_hdr", hdr_log[hdr_log.size()-1], 64'h1234_5678_0010_9739);

        // T2
        send_word(16'h0000, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        wait_idle();
        check("t2_hdr", hdr_log[hdr_log.size()-1], 64'h0000_0000_0010_FFEF);

        // T3
        send_word(16'hFFEF, 16'h0000, 64'd0, 1'b1);
        wait_idle();
        check("t3_hdr", hdr_log[hdr_log.size()-1], 64'hFFEF_0000_0010_FFFF);

        // T4: stalled output
        toggle = 1; pi = 0; x0 = xfers;
        for (int i = 1; i <= 3; i++)
            send_word(16'h1111, 16'h2222, {16'(i), 16'(i*3), 16'hA5A5, 16'(i*7)}, i == 3);
        wait_idle();
        toggle = 0;
        check("t4_xfers", 64'(xfers - x0), 64'd4);
        check("t4_len", 64'(hdr_log[hdr_log.size()-1][31:16]), 64'h0020);

        // T5: in_last never set; buffer fills, remainder opens a new datagram
        base = hdr_log.size();
        for (int i = 0; i < MAXW + 2; i++)
            send_word(16'h0BAD, 16'hF00D, {16'(i), 16'(i+1), 16'(i*5), 16'hFFFF}, 1'b0);
        send_word(16'h0BAD, 16'hF00D, 64'h1234_0000_5678_0000, 1'b1);
        wait_idle();
        n = hdr_log.size() - base;
        check("t5_ndgrams", 64'(n), 64'd2);
        if (n >= 2) begin
            check("t5_len_full", 64'(hdr_log[base][31:16]), 64'(8 + 8*MAXW));
            check("t5_len_rest", 64'(hdr_log[base+1][31:16]), 64'h0020);
        end

        // T6: reset while in DATA
        for (int i = 0; i < 4; i++)
            send_word(16'hAAAA, 16'h5555, {4{16'(i+9)}}, i == 3);
        n = 0;
        while (expq.size() > 2 && n < 200) begin @(posedge clk); #2; n++; end
        if (n >= 200) fail_now("t6_reach_data");
        rst = 1'b1;
        #1;
        check("t6_out_valid", bus.out_valid, 1'b0);
        check("t6_out_last", bus.out_last, 1'b0);
        check("t6_out_data", bus.out_data, 64'd0);
        check("t6_in_ready", bus.in_ready, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_done", done, 1'b0);
        expq.delete(); cur.delete(); done_pend = 0; prev_stall = 0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        send_word(16'h0102, 16'h0304, 64'd0, 1'b1);
        wait_idle();
        check("t6_hdr", hdr_log[hdr_log.size()-1], 64'h0102_0304_0010_FBE9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
